frame_builder: RTL and testbench

- Builds one complete 8x16 LED-matrix frame from a stream of lit-pixel coordinates.
- Sources: snake body segments and food, emitted by the game-logic stage.
- Draws into a private back buffer, then swaps it atomically into the front buffer.
- The front buffer drives the pixelReg bus of the matrix scanner, so the scanner never shows a half-drawn frame.

---
 rtl/frame_builder_if.sv | 28 ++
 rtl/frame_builder.sv | 117 +++++++++++
 tb/tb_frame_builder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_builder_if.sv
// Pixel stream, frame control and front-buffer bus between the game logic (master) and frame_builder (slave).
interface frame_builder_if #(
  parameter int ROWS = 8,
  parameter int COLS = 16,
  parameter int XW   = 4,
  parameter int YW   = 3
);
  logic                 frame_start;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic                 pix_last;
  logic                 busy;
  logic                 frame_done;
  logic                 collision;
  logic [ROWS*COLS-1:0] pixelReg;

  modport master (
    output frame_start, pix_valid, pix_x, pix_y, pix_last,
    input  pix_ready, busy, frame_done, collision, pixelReg
  );

  modport slave (
    input  frame_start, pix_valid, pix_x, pix_y, pix_last,
    output pix_ready, busy, frame_done, collision, pixelReg
  );
endinterface

// File: rtl/frame_builder.sv
// Clears a back buffer (ROWS cycles), draws streamed pixels (pix_ready only in DRAW), swaps into pixelReg one cycle after pix_last.
// Optional FRAME_BUILDER_COLLISION_EN: sticky collision flag when a pixel lands on an already-lit bit.
module frame_builder #(
  parameter int ROWS = 8,
  parameter int COLS = 16,
  parameter int XW   = 4,
  parameter int YW   = 3
) (
  input  logic             clk,
  input  logic             aclr,
  frame_builder_if.slave   bus
);
  localparam int NB = ROWS * COLS;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, SWAP} state_t;

  state_t          state, state_nxt;
  logic [NB-1:0]   back;
  logic [NB-1:0]   front;
  logic [CW-1:0]   row_cnt;
  logic            busy_q;
  logic            done_q;

  logic            pix_ready;
  logic            start_frame;
  logic            clear_row;
  logic            accept;
  logic            do_swap;
  logic            in_range;
  logic [IW-1:0]   pix_idx;

  assign in_range = (int'(bus.pix_x) < COLS) && (int'(bus.pix_y) < ROWS);
  assign pix_idx  = IW'(COLS * int'(bus.pix_y) + int'(bus.pix_x));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pix_ready   = 1'b0;
    start_frame = 1'b0;
    clear_row   = 1'b0;
    accept      = 1'b0;
    do_swap     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          start_frame = 1'b1;
          state_nxt   = CLEAR;
        end
      end
      CLEAR: begin
        clear_row = 1'b1;
        if (row_cnt == CW'(ROWS - 1)) state_nxt = DRAW;
      end
      DRAW: begin
        pix_ready = 1'b1;
        accept    = bus.pix_valid;
        if (bus.pix_valid && bus.pix_last) state_nxt = SWAP;
      end
      SWAP: begin
        do_swap   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      back    <= '0;
      front   <= '0;
      row_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= do_swap;
      if (start_frame) begin
        busy_q  <= 1'b1;
        row_cnt <= '0;
      end
      if (clear_row) begin
        back[COLS*row_cnt +: COLS] <= '0;
        row_cnt                    <= row_cnt + 1'b1;
      end
      // Out-of-range coordinates are consumed but never touch the buffer.
      if (accept && in_range) back[pix_idx] <= 1'b1;
      if (do_swap) begin
        front  <= back;
        busy_q <= 1'b0;
      end
    end
  end

`ifdef FRAME_BUILDER_COLLISION_EN
  logic coll_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)                                     coll_q <= 1'b0;
    else if (start_frame)                         coll_q <= 1'b0;
    else if (accept && in_range && back[pix_idx]) coll_q <= 1'b1;
  end

  assign bus.collision = coll_q;
`else
  assign bus.collision = 1'b0;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.pixelReg   = front;
endmodule

// File: tb/tb_frame_builder.sv
// Randomized and directed frames checked against a 2-D pixel-array model of the frame builder.
module tb_frame_builder;
  localparam int ROWS = 8;
  localparam int COLS = 16;
  localparam int XW   = 4;
  localparam int YW   = 3;
  localparam int NB   = ROWS * COLS;

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic clk = 1'b0;
  logic aclr;
  int   checks = 0;
  int   errors = 0;

  pix_t          frame_q[$];
  logic [NB-1:0] front_model = '0;

  always #5 clk = ~clk;

  frame_builder_if #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) bus ();

  frame_builder #(.ROWS(ROWS), .COLS(COLS), .XW(XW), .YW(YW)) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected picture: light each in-range coordinate in a 2-D array, note any repeat.
  function automatic void model(output logic [NB-1:0] img, output bit coll);
    bit lit[ROWS][COLS];
    img  = '0;
    coll = 1'b0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) lit[y][x] = 1'b0;
    foreach (frame_q[i]) begin
      if (frame_q[i].x < COLS && frame_q[i].y < ROWS) begin
        if (lit[frame_q[i].y][frame_q[i].x]) coll = 1'b1;
        lit[frame_q[i].y][frame_q[i].x] = 1'b1;
      end
    end
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) img[y*COLS + x] = lit[y][x];
`ifndef FRAME_BUILDER_COLLISION_EN
    coll = 1'b0;
`endif
  endfunction

  function automatic void push(input int x, input int y);
    pix_t p;
    p.x = x;
    p.y = y;
    frame_q.push_back(p);
  endfunction

  // gap < 0 picks a random 0..2 idle gap before each pixel; abort_after >= 0 resets after that many pixels.
  task automatic run_frame(input int gap, input bit pulse_start, input int abort_after);
    logic [NB-1:0] exp_img;
    bit            exp_coll;
    int            n;
    int            g;
    model(exp_img, exp_coll);

    @(negedge clk);
    bus.frame_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.frame_start = pulse_start && (n == 3);
      chk("busy_clear", NB'(bus.busy), NB'(1));
      chk("front_clear", bus.pixelReg, front_model);
    end while (!bus.pix_ready && n < 40);
    bus.frame_start = 1'b0;
    chk("clear_len", NB'(n), NB'(ROWS + 1));
    chk("coll_cleared", NB'(bus.collision), NB'(0));

    for (int i = 0; i < frame_q.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        bus.pix_valid = 1'b0;
        @(negedge clk);
        chk("front_gap", bus.pixelReg, front_model);
      end
      if (abort_after == i) begin
        #1 aclr = 1'b1;
        #1;
        chk("rst_pixel", bus.pixelReg, '0);
        chk("rst_busy", NB'(bus.busy), NB'(0));
        chk("rst_ready", NB'(bus.pix_ready), NB'(0));
        chk("rst_done", NB'(bus.frame_done), NB'(0));
        chk("rst_coll", NB'(bus.collision), NB'(0));
        @(negedge clk);
        aclr = 1'b0;
        front_model = '0;
        @(negedge clk);
        chk("rst_idle", NB'(bus.pix_ready), NB'(0));
        return;
      end
      bus.pix_valid   = 1'b1;
      bus.pix_x       = frame_q[i].x[XW-1:0];
      bus.pix_y       = frame_q[i].y[YW-1:0];
      bus.pix_last    = (i == frame_q.size() - 1);
      bus.frame_start = pulse_start && (i == 0);
      @(negedge clk);
      bus.pix_valid   = 1'b0;
      bus.pix_last    = 1'b0;
      bus.frame_start = 1'b0;
      chk("front_draw", bus.pixelReg, front_model);
    end

    chk("swap_ready", NB'(bus.pix_ready), NB'(0));
    chk("swap_done0", NB'(bus.frame_done), NB'(0));
    chk("swap_busy", NB'(bus.busy), NB'(1));
    @(negedge clk);
    chk("done_pulse", NB'(bus.frame_done), NB'(1));
    chk("pixel", bus.pixelReg, exp_img);
    chk("busy_end", NB'(bus.busy), NB'(0));
    chk("collision", NB'(bus.collision), NB'(exp_coll));
    front_model = exp_img;
    @(negedge clk);
    chk("done_once", NB'(bus.frame_done), NB'(0));
    chk("front_hold", bus.pixelReg, front_model);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] ref_img;
    int            len;
    aclr            = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.pix_last    = 1'b0;
    #1;
    chk("reset_pixel", bus.pixelReg, '0);
    chk("reset_busy", NB'(bus.busy), NB'(0));
    chk("reset_done", NB'(bus.frame_done), NB'(0));
    chk("reset_coll", NB'(bus.collision), NB'(0));
    repeat (2) @(negedge clk);
    aclr = 1'b0;

    // Pixels offered while idle must be refused.
    bus.pix_valid = 1'b1;
    bus.pix_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", NB'(bus.pix_ready), NB'(0));
      chk("idle_busy", NB'(bus.busy), NB'(0));
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;

    frame_q = {};
    push(0, 0);
    push(15, 7);
    run_frame(0, 1'b0, -1);
    ref_img = '0;
    ref_img[0]   = 1'b1;
    ref_img[127] = 1'b1;
    chk("corners", bus.pixelReg, ref_img);

    frame_q = {};
    push(3, 2);
    run_frame(0, 1'b0, -1);
    ref_img = '0;
    ref_img[35] = 1'b1;
    chk("single_px", bus.pixelReg, ref_img);

    frame_q = {};
    push(5, 1);
    run_frame(5, 1'b1, -1);
    ref_img = '0;
    ref_img[21] = 1'b1;
    chk("gap_px", bus.pixelReg, ref_img);

    frame_q = {};
    push(4, 4);
    push(4, 4);
    run_frame(0, 1'b0, -1);

    frame_q = {};
    push(1, 1);
    run_frame(0, 1'b0, -1);

    frame_q = {};
    push(2, 2);
    push(6, 3);
    push(9, 5);
    run_frame(0, 1'b0, 2);

    frame_q = {};
    push(7, 6);
    run_frame(0, 1'b0, -1);

    for (int f = 0; f < 20; f++) begin
      frame_q = {};
      len = int'($urandom_range(1, 10));
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 4) == 0) frame_q.push_back(frame_q[0]);
        else push(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)));
      end
      run_frame(-1, 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
